// File: rtl/iobus_uart_pkg.sv
// Shared types and register-map constants for the IOBUS UART receiver.
package iobus_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Register offsets from BASE_AD
    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] CTRL_OFS = 32'd4;

    // CTRL store bits
    localparam int unsigned POP_B   = 0;
    localparam int unsigned CLR_B   = 1;
    localparam int unsigned FLUSH_B = 2;

    // STATUS read bits; count occupies [15:8]
    localparam int unsigned ST_EMPTY_B = 0;
    localparam int unsigned ST_FULL_B  = 1;
    localparam int unsigned ST_FERR_B  = 2;
    localparam int unsigned ST_OVR_B   = 3;
    localparam int unsigned ST_CNT_LSB = 8;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with flush; pop on empty is ignored, push on full is dropped.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [7:0]                 din_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [7:0]                 dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_eff, push_eff;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign count_o  = count_q;
    assign dout_o   = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
    assign pop_eff  = pop_i & ~empty_o & ~flush_i;
    assign push_eff = push_i & ~flush_i & (~full_o | pop_eff);
    assign drop_o   = push_i & ~flush_i & full_o & ~pop_eff;

    // Next-state for pointers and occupancy; flush overrides everything
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Pointer and count state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_eff) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/iobus_uart_rx.sv
// Memory-mapped 8N1 UART receiver for the OTTER IOBUS with byte FIFO and arrival interrupt.
module iobus_uart_rx
    import iobus_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_AD    = 32'h1100_0180
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        HIT,
    output logic        INTR
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(DIV - 1);

    logic             sync1_q, sync2_q, rx_s;
    rx_state_t        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             push_q, ferr_set_q;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             intr_q, intr_d;
    logic             hit_data, hit_ctrl, wr_ctrl;
    logic             pop, clr, flush;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      status;
    logic             unused_wdata;

    assign unused_wdata = ^IOBUS_OUT[31:3];

    // Two-flop synchroniser; idles high so reset must not look like a start bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

    // Receive FSM: mid-bit sampling via half-period start delay, registered push/error strobes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt_q <= HALF_LD;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_cnt_q == '0) begin
                        if (!rx_s) begin
                            baud_cnt_q <= FULL_LD;
                            bit_cnt_q  <= '0;
                            state_q    <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt_q == '0) begin
                        shift_q    <= {rx_s, shift_q[7:1]};
                        baud_cnt_q <= FULL_LD;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt_q == '0) begin
                        push_q     <= rx_s;
                        ferr_set_q <= ~rx_s;
                        state_q    <= IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hit_data = (IOBUS_ADDR == BASE_AD + DATA_OFS);
    assign hit_ctrl = (IOBUS_ADDR == BASE_AD + CTRL_OFS);
    assign HIT      = hit_data | hit_ctrl;
    assign wr_ctrl  = IOBUS_WR & hit_ctrl;
    assign pop      = wr_ctrl & IOBUS_OUT[POP_B];
    assign clr      = wr_ctrl & IOBUS_OUT[CLR_B];
    assign flush    = wr_ctrl & IOBUS_OUT[FLUSH_B];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push_q),
        .din_i   (shift_q),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .count_o (fifo_count)
    );

    // Sticky flags (a new event outranks a same-cycle clear) and the arrival pulse
    always_comb begin
        overrun_d   = (overrun_q & ~clr) | fifo_drop;
        frame_err_d = (frame_err_q & ~clr) | ferr_set_q;
        intr_d      = push_q & ~flush & fifo_empty;
    end

    // Flag and interrupt registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            intr_q      <= intr_d;
        end
    end
    assign INTR = intr_q;

    // Read mux, combinational from current state
    always_comb begin
        status                              = '0;
        status[ST_EMPTY_B]                  = fifo_empty;
        status[ST_FULL_B]                   = fifo_full;
        status[ST_FERR_B]                   = frame_err_q;
        status[ST_OVR_B]                    = overrun_q;
        status[ST_CNT_LSB +: 8]             = 8'(fifo_count);
        IOBUS_IN                            = '0;
        if (hit_data)      IOBUS_IN = {23'b0, ~fifo_empty, fifo_dout};
        else if (hit_ctrl) IOBUS_IN = status;
    end

endmodule

// File: tb/tb_iobus_uart_rx.sv
// Randomised self-checking bench for iobus_uart_rx against a queue-based model.
module tb_iobus_uart_rx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned BIT_T  = CLK_HZ / BAUD;
    localparam logic [31:0] BASE   = 32'h1100_0180;
    localparam logic [31:0] CTRL   = 32'h1100_0184;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic        intr;

    int n_checks = 0;
    int n_fail   = 0;
    int intr_cnt = 0;

    byte unsigned m_q[$];
    bit           m_ovr = 1'b0;
    bit           m_fe  = 1'b0;

    iobus_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .BASE_AD    (BASE)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .RX         (rx),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (wdata),
        .IOBUS_WR   (wr),
        .IOBUS_IN   (rdata),
        .HIT        (hit),
        .INTR       (intr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (intr === 1'b1) intr_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected run to end");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[15:8]  = 8'(m_q.size());
        s[3]     = m_ovr;
        s[2]     = m_fe;
        s[1]     = (m_q.size() == DEPTH);
        s[0]     = (m_q.size() == 0);
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        if (m_q.size() == 0) return 32'h0;
        return {23'b0, 1'b1, m_q[0]};
    endfunction

    task automatic io_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        addr = a;
        #1;
        d = rdata;
        h = hit;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        logic        h;
        io_read(CTRL, d, h);
        check_eq(tag, d, exp_status());
    endtask

    task automatic chk_data(input string tag);
        logic [31:0] d;
        logic        h;
        io_read(BASE, d, h);
        check_eq(tag, d, exp_data());
    endtask

    // One 8N1 frame at BIT_T clocks per bit, followed by an idle gap
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_T) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (BIT_T) @(posedge clk);
        end
        #1 rx = stop;
        repeat (BIT_T) @(posedge clk);
        #1 rx = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    // Model update for a received frame, without any concurrent CPU action
    task automatic rx_byte(input logic [7:0] b, input logic stop, input string tag);
        int i0;
        int exp_i;
        i0    = intr_cnt;
        exp_i = (stop && m_q.size() == 0) ? 1 : 0;
        send_frame(b, stop);
        if (!stop) m_fe = 1'b1;
        else if (m_q.size() == DEPTH) m_ovr = 1'b1;
        else m_q.push_back(b);
        check_eq({tag, "_intr"}, 32'(intr_cnt - i0), 32'(exp_i));
    endtask

    task automatic pop_check(input string tag);
        chk_data(tag);
        store(CTRL, 32'h1);
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        int          i0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check_eq("rst_intr", {31'b0, intr}, 32'h0);
        chk_status("rst_status");
        chk_data("rst_data");

        // Single byte
        rx_byte(8'h5A, 1'b1, "b5a");
        chk_status("b5a_status");
        check_eq("b5a_status_abs", exp_status(), 32'h0000_0100);
        chk_data("b5a_data");
        store(CTRL, 32'h1);
        void'(m_q.pop_front());
        chk_status("b5a_pop_status");
        chk_data("b5a_pop_data");

        // Glitch: too short to survive the start-bit recheck
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        chk_status("glitch_status");

        // Frame error then clear
        rx_byte(8'hA5, 1'b0, "ferr");
        chk_status("ferr_status");
        store(CTRL, 32'h2);
        m_fe = 1'b0;
        chk_status("ferr_clr_status");

        // Overrun: nine bytes into an eight-entry FIFO
        for (int i = 0; i < 9; i++) rx_byte(8'(i), 1'b1, "ovr");
        chk_status("ovr_status");
        for (int i = 0; i < 8; i++) pop_check("ovr_pop");
        chk_status("ovr_drained");
        store(CTRL, 32'h2);
        m_ovr = 1'b0;

        // Pop landing in the exact cycle of the push into a full FIFO
        for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i), 1'b1, "fill");
        chk_status("fill_status");
        i0 = intr_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(posedge clk);
                repeat (98) @(posedge clk);
                #1;
                addr  = CTRL;
                wdata = 32'h1;
                wr    = 1'b1;
                @(posedge clk);
                #1 wr = 1'b0;
            end
        join
        void'(m_q.pop_front());
        m_q.push_back(8'h77);
        check_eq("pp_intr", 32'(intr_cnt - i0), 32'h0);
        chk_status("pp_status");
        for (int i = 0; i < 8; i++) pop_check("pp_pop");
        chk_status("pp_empty");

        // Flush
        for (int i = 0; i < 3; i++) rx_byte(8'hE0 + 8'(i), 1'b1, "fl");
        chk_status("fl_pre");
        store(CTRL, 32'h4);
        m_q.delete();
        chk_status("fl_status");

        // Reset mid-frame with state present beforehand
        rx_byte(8'h99, 1'b1, "pre_rst");
        rx_byte(8'h42, 1'b0, "pre_rst_err");
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_T) @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_T * 2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (BIT_T + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        repeat (20) @(posedge clk);
        chk_status("rst_mid_status");
        chk_data("rst_mid_data");
        rx_byte(8'hC3, 1'b1, "c3");
        chk_data("c3_data");
        chk_status("c3_status");

        // Decode
        io_read(32'h1100_0000, d, h);
        check_eq("dec_miss_hit", {31'b0, h}, 32'h0);
        check_eq("dec_miss_data", d, 32'h0);
        io_read(BASE, d, h);
        check_eq("dec_base_hit", {31'b0, h}, 32'h1);
        io_read(CTRL, d, h);
        check_eq("dec_ctrl_hit", {31'b0, h}, 32'h1);
        store(BASE, 32'h1);
        chk_status("dec_nopop");
        pop_check("dec_pop");

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            logic [7:0]  b;
            logic        err;
            logic [31:0] ctl;
            b   = 8'($urandom);
            err = ($urandom_range(0, 6) == 0);
            rx_byte(b, ~err, "rnd");
            ctl = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) ctl[0] = 1'b0;
            if (ctl[0]) chk_data("rnd_data");
            if (ctl != 0) begin
                store(CTRL, ctl);
                if (ctl[0] && m_q.size() != 0) void'(m_q.pop_front());
                if (ctl[1]) begin
                    m_ovr = 1'b0;
                    m_fe  = 1'b0;
                end
            end
            chk_status("rnd_status");
        end
        while (m_q.size() != 0) pop_check("rnd_drain");
        chk_status("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
